// File: rtl/conv1_pkg.sv
// Shared conv1/pool1 types and geometry constants.
// Imported by the pool1 collector and its quantiser.
package conv1_pkg;

  localparam int unsigned CONV1_OUT_H = 14;
  localparam int unsigned CONV1_OUT_W = 13;
  localparam int unsigned CONV1_CHAN  = 10;
  localparam int unsigned POOL1_H     = CONV1_OUT_H / 2;
  localparam int unsigned POOL1_W     = CONV1_OUT_W / 2;
  localparam int unsigned QUANT_SHIFT = 8;

  typedef logic signed [23:0] acc_t;
  typedef logic        [7:0]  pix_t;

  typedef enum logic [1:0] {
    StIdle,
    StPool,
    StDone
  } pool1_state_e;

endpackage

// File: rtl/pool_quant_unit.sv
// 2x2 max-pool of signed accumulators followed by ReLU, arithmetic shift
// and saturation to an unsigned 8-bit pixel. Purely combinational.
module pool_quant_unit
  import conv1_pkg::*;
#(
  parameter int unsigned SHIFT = QUANT_SHIFT
) (
  input  acc_t a_i,
  input  acc_t b_i,
  input  acc_t c_i,
  input  acc_t d_i,
  output pix_t pix_o
);

  acc_t max_ab;
  acc_t max_cd;
  acc_t max_all;
  acc_t shifted;

  always_comb begin
    max_ab  = (a_i > b_i) ? a_i : b_i;
    max_cd  = (c_i > d_i) ? c_i : d_i;
    max_all = (max_ab > max_cd) ? max_ab : max_cd;
    shifted = max_all >>> SHIFT;
    if (max_all[23]) begin
      pix_o = '0;
    end else if (shifted > acc_t'(255)) begin
      pix_o = 8'hFF;
    end else begin
      pix_o = shifted[7:0];
    end
  end

endmodule

// File: rtl/pool1_collector.sv
// Captures each conv1 channel map, pools/quantises it one pixel per cycle
// into the per-channel feature-map array and tracks channel ordering.
module pool1_collector
  import conv1_pkg::*;
#(
  parameter int unsigned IN_H  = CONV1_OUT_H,
  parameter int unsigned IN_W  = CONV1_OUT_W,
  parameter int unsigned CHAN  = CONV1_CHAN,
  parameter int unsigned SHIFT = QUANT_SHIFT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic [3:0] in_chan_i,
  input  acc_t       in_map_i [IN_H][IN_W],
  output pix_t       fmap_o [CHAN][IN_H/2][IN_W/2],
  output logic       busy_o,
  output logic       chan_done_o,
  output logic       all_done_o,
  output logic       err_overrun_o,
  output logic       err_chan_o
);

  localparam int unsigned P_H = IN_H / 2;
  localparam int unsigned P_W = IN_W / 2;
  localparam int unsigned RW  = $clog2(P_H);
  localparam int unsigned CW  = $clog2(P_W);

  localparam logic [RW-1:0] LastRow  = RW'(P_H - 1);
  localparam logic [CW-1:0] LastCol  = CW'(P_W - 1);
  localparam logic [3:0]    LastChan = 4'(CHAN - 1);

  pool1_state_e  state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [3:0]    cur_chan_q;
  logic [3:0]    exp_chan_q;
  logic          busy_q;
  logic          chan_done_q;
  logic          all_done_q;
  logic          err_overrun_q;
  logic          err_chan_q;

  acc_t snap_q [IN_H][IN_W];
  pix_t fmap_q [CHAN][P_H][P_W];

  logic        chan_ok;
  logic        accept;
  logic [RW:0] r0, r1;
  logic [CW:0] c0, c1;
  pix_t        pool_pix;

  always_comb begin
    chan_ok = (in_chan_i <= LastChan);
    accept  = (state_q == StIdle) && in_valid_i && chan_ok;
    r0      = {row_q, 1'b0};
    r1      = {row_q, 1'b1};
    c0      = {col_q, 1'b0};
    c1      = {col_q, 1'b1};
  end

  pool_quant_unit #(
    .SHIFT(SHIFT)
  ) u_pool_quant (
    .a_i  (snap_q[r0][c0]),
    .b_i  (snap_q[r0][c1]),
    .c_i  (snap_q[r1][c0]),
    .d_i  (snap_q[r1][c1]),
    .pix_o(pool_pix)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      cur_chan_q    <= '0;
      exp_chan_q    <= '0;
      busy_q        <= 1'b0;
      chan_done_q   <= 1'b0;
      all_done_q    <= 1'b0;
      err_overrun_q <= 1'b0;
      err_chan_q    <= 1'b0;
    end else begin
      chan_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            if (!chan_ok) begin
              err_chan_q <= 1'b1;
            end else begin
              // Out-of-order channels are still stored in their own slot.
              if (in_chan_i != exp_chan_q) err_chan_q <= 1'b1;
              if (in_chan_i == 4'd0) all_done_q <= 1'b0;
              cur_chan_q <= in_chan_i;
              row_q      <= '0;
              col_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= StPool;
            end
          end
        end
        StPool: begin
          if (in_valid_i) err_overrun_q <= 1'b1;
          if (col_q == LastCol) begin
            col_q <= '0;
            if (row_q == LastRow) begin
              row_q       <= '0;
              busy_q      <= 1'b0;
              chan_done_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StDone: begin
          if (in_valid_i) err_overrun_q <= 1'b1;
          exp_chan_q <= (cur_chan_q == LastChan) ? 4'd0 : cur_chan_q + 4'd1;
          if (cur_chan_q == LastChan) all_done_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < IN_H; i++) begin
        for (int j = 0; j < IN_W; j++) begin
          snap_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      snap_q <= in_map_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < CHAN; k++) begin
        for (int i = 0; i < P_H; i++) begin
          for (int j = 0; j < P_W; j++) begin
            fmap_q[k][i][j] <= '0;
          end
        end
      end
    end else if (state_q == StPool) begin
      fmap_q[cur_chan_q][row_q][col_q] <= pool_pix;
    end
  end

  assign fmap_o        = fmap_q;
  assign busy_o        = busy_q;
  assign chan_done_o   = chan_done_q;
  assign all_done_o    = all_done_q;
  assign err_overrun_o = err_overrun_q;
  assign err_chan_o    = err_chan_q;

endmodule

// File: tb/tb_pool1_collector.sv
// Randomised scoreboard bench for pool1_collector: stimulus pushes expected
// channel results, a monitor pops and checks them on every chan_done pulse.
module tb_pool1_collector;
  import conv1_pkg::*;

  localparam int IN_H  = CONV1_OUT_H;
  localparam int IN_W  = CONV1_OUT_W;
  localparam int CHAN  = CONV1_CHAN;
  localparam int SHIFT = QUANT_SHIFT;
  localparam int P_H   = IN_H / 2;
  localparam int P_W   = IN_W / 2;
  localparam int P_N   = P_H * P_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_chan;
  acc_t       in_map [IN_H][IN_W];
  pix_t       fmap [CHAN][P_H][P_W];
  logic       busy, chan_done, all_done, err_overrun, err_chan;

  always #5 clk = ~clk;

  pool1_collector #(
    .IN_H (IN_H),
    .IN_W (IN_W),
    .CHAN (CHAN),
    .SHIFT(SHIFT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_chan_i    (in_chan),
    .in_map_i     (in_map),
    .fmap_o       (fmap),
    .busy_o       (busy),
    .chan_done_o  (chan_done),
    .all_done_o   (all_done),
    .err_overrun_o(err_overrun),
    .err_chan_o   (err_chan)
  );

  typedef struct packed {
    logic [3:0]            ch;
    int                    due;
    logic [P_N-1:0][7:0]   px;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         map_v [IN_H][IN_W];
  logic [7:0] shadow [CHAN][P_H][P_W];
  int         idle_at = 0;
  int         m_exp = 0;
  int         last_t = 0;
  bit         m_all_done = 0;
  bit         m_err_ov = 0;
  bit         m_err_ch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: max of the 2x2 window, ReLU, divide by 2^SHIFT, clamp to 255.
  function automatic int ref_pix(input int r, input int c);
    int m;
    m = map_v[2*r][2*c];
    if (map_v[2*r][2*c+1] > m) m = map_v[2*r][2*c+1];
    if (map_v[2*r+1][2*c] > m) m = map_v[2*r+1][2*c];
    if (map_v[2*r+1][2*c+1] > m) m = map_v[2*r+1][2*c+1];
    if (m < 0) return 0;
    m = m / (1 << SHIFT);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic rand_map();
    for (int i = 0; i < IN_H; i++) begin
      for (int j = 0; j < IN_W; j++) begin
        case ($urandom_range(0, 3))
          0: map_v[i][j] = int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
          1: map_v[i][j] = int'($urandom_range(0, 74000)) - 4000;
          2: map_v[i][j] = int'($urandom_range(0, 65535));
          default: map_v[i][j] = -int'($urandom_range(0, 100000));
        endcase
      end
    end
  endtask

  task automatic send(input int ch);
    exp_t e;
    int   t;
    @(negedge clk);
    for (int i = 0; i < IN_H; i++)
      for (int j = 0; j < IN_W; j++) in_map[i][j] = acc_t'(map_v[i][j]);
    in_chan  = 4'(ch);
    in_valid = 1'b1;
    t        = cyc + 1;
    last_t   = t;
    if (t < idle_at) begin
      m_err_ov = 1;
    end else if (ch >= CHAN) begin
      m_err_ch = 1;
    end else begin
      if (ch != m_exp) m_err_ch = 1;
      if (ch == 0) m_all_done = 0;
      e.ch  = 4'(ch);
      e.due = t + 42;
      for (int r = 0; r < P_H; r++)
        for (int c = 0; c < P_W; c++) e.px[r*P_W+c] = 8'(ref_pix(r, c));
      sb.push_back(e);
      idle_at = t + 44;
      m_exp   = (ch == CHAN - 1) ? 0 : ch + 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   bad;
    if (!rst && chan_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_chan_done: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_latency", cyc, e.due);
        chk("busy_in_done", int'(busy), 0);
        bad = 0;
        n_checks++;
        for (int r = 0; r < P_H; r++) begin
          for (int c = 0; c < P_W; c++) begin
            if (fmap[e.ch][r][c] !== e.px[r*P_W+c]) begin
              if (bad == 0)
                $display("FAIL fmap_ch%0d[%0d][%0d]: got %0d, expected %0d", e.ch, r, c,
                         fmap[e.ch][r][c], e.px[r*P_W+c]);
              bad++;
            end
            shadow[e.ch][r][c] = e.px[r*P_W+c];
          end
        end
        if (bad != 0) n_fail++;
        if (int'(e.ch) == CHAN - 1) m_all_done = 1;
      end
    end
  end

  task automatic compare_all(input string name);
    int bad = 0;
    n_checks++;
    for (int k = 0; k < CHAN; k++)
      for (int r = 0; r < P_H; r++)
        for (int c = 0; c < P_W; c++)
          if (fmap[k][r][c] !== shadow[k][r][c]) begin
            if (bad == 0)
              $display("FAIL %s fmap[%0d][%0d][%0d]: got %0d, expected %0d", name, k, r, c,
                       fmap[k][r][c], shadow[k][r][c]);
            bad++;
          end
    if (bad != 0) n_fail++;
  endtask

  task automatic check_flags(input string name);
    chk({name, "_all_done"}, int'(all_done), int'(m_all_done));
    chk({name, "_err_overrun"}, int'(err_overrun), int'(m_err_ov));
    chk({name, "_err_chan"}, int'(err_chan), int'(m_err_ch));
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !chan_done) break;
    end
    if (k >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got busy after 400 cycles, expected idle", name);
    end
    @(negedge clk);
  endtask

  task automatic zero_model();
    sb.delete();
    for (int k = 0; k < CHAN; k++)
      for (int r = 0; r < P_H; r++)
        for (int c = 0; c < P_W; c++) shadow[k][r][c] = '0;
    idle_at = 0;
    m_exp = 0;
    m_all_done = 0;
    m_err_ov = 0;
    m_err_ch = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_chan_done"}, int'(chan_done), 0);
    check_flags(name);
    compare_all(name);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    zero_model();
    check_reset_outputs(name);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_chan  = '0;
    for (int i = 0; i < IN_H; i++)
      for (int j = 0; j < IN_W; j++) in_map[i][j] = '0;
    zero_model();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Ordered ramp on channel 0.
    for (int i = 0; i < IN_H; i++)
      for (int j = 0; j < IN_W; j++) map_v[i][j] = (i * IN_W + j) * 256;
    send(0);
    chk("busy_after_accept", int'(busy), 1);
    wait_drain("ramp");
    chk("ramp_px00", int'(fmap[0][0][0]), 14);
    chk("ramp_px65", int'(fmap[0][6][5]), 13 * IN_W + 11);
    check_flags("ramp");

    // Negative, saturating and sub-shift windows on channel 1.
    rand_map();
    map_v[0][0] = -5000; map_v[0][1] = -1;  map_v[1][0] = -300; map_v[1][1] = -7;
    map_v[0][2] = 70000; map_v[0][3] = 12;  map_v[1][2] = -9;   map_v[1][3] = 100;
    map_v[0][4] = 255;   map_v[0][5] = 3;   map_v[1][4] = -20;  map_v[1][5] = 0;
    send(1);
    wait_drain("window");
    chk("neg_window", int'(fmap[1][0][0]), 0);
    chk("sat_window", int'(fmap[1][0][1]), 255);
    chk("subshift_window", int'(fmap[1][0][2]), 0);

    // Remaining channels at the conv1 cadence.
    for (int k = 2; k < CHAN; k++) begin
      rand_map();
      send(k);
      repeat (182) @(negedge clk);
    end
    wait_drain("image");
    chk("all_done_set", int'(all_done), 1);
    check_flags("image");
    compare_all("image");

    rand_map();
    send(0);
    repeat (2) @(negedge clk);
    chk("all_done_clear", int'(all_done), 0);
    wait_drain("restart");

    // Overrun: second frame 10 cycles after the first is dropped.
    rand_map();
    send(1);
    repeat (8) @(negedge clk);
    rand_map();
    send(2);
    wait_drain("overrun");
    chk("err_overrun_set", int'(err_overrun), 1);
    check_flags("overrun");
    compare_all("overrun");

    // Out-of-order channel is still written; out-of-range channel is dropped.
    rand_map();
    send(3);
    wait_drain("order");
    chk("err_chan_set", int'(err_chan), 1);
    compare_all("order");
    rand_map();
    send(12);
    chk("busy_bad_chan", int'(busy), 0);
    wait_drain("range");
    check_flags("range");
    compare_all("range");

    // Reset in the middle of pooling, then a clean frame.
    rand_map();
    send(0);
    while (cyc < last_t + 19) @(negedge clk);
    do_reset("mid_reset");
    rand_map();
    send(0);
    wait_drain("post_reset");
    check_flags("post_reset");
    compare_all("post_reset");

    // Random channel order and spacing.
    for (int n = 0; n < 25; n++) begin
      rand_map();
      ch = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, 12));
      send(ch);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_drain("random");
    check_flags("random");
    compare_all("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
